// File: rtl/alu_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq_if
// Bundles the instruction-memory, data-memory and ALU connections of the
// alu_ctrl_seq sequencer.
//   master : sequencer side (drives requests, addresses, ALU operands/controls)
//   slave  : memory/ALU side (drives acks, read data, ALU result and flags)
// Signals:
//   imem_req/imem_addr/imem_ack/imem_data             instruction fetch port
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/
//   dmem_rdata/dmem_ack                               data memory port
//   alu_x/alu_y/zx/nx/zy/ny/f/no                      ALU operands and controls
//   alu_o/alu_zr/alu_ng                               ALU result and flags
// ---------------------------------------------------------------------------
interface alu_ctrl_seq_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_data;

    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    logic [DW-1:0] alu_x;
    logic [DW-1:0] alu_y;
    logic          zx, nx, zy, ny, f, no;
    logic [DW-1:0] alu_o;
    logic          alu_zr;
    logic          alu_ng;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack,
        output alu_x, alu_y, zx, nx, zy, ny, f, no,
        input  alu_o, alu_zr, alu_ng
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack,
        input  alu_x, alu_y, zx, nx, zy, ny, f, no,
        output alu_o, alu_zr, alu_ng
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
// Hack-style instruction sequencer for an external combinational ALU.
// Fetches 16-bit instructions, decodes A/C instructions, supplies ALU
// operands and control bits, writes back results to A/D/memory and
// resolves jumps. Owns the A, D and PC registers.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      alu_ctrl_seq_if.master: imem, dmem and ALU connections
//   pc_o     current PC (debug)
//   a_o,d_o  current A and D registers (debug)
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.master bus,
    output logic [AW-1:0] pc_o,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] d_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEMRD  = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMWR  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_run;     // low for the first clock after reset so no request is raised during reset
    logic [15:0]   r_ir;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic [DW-1:0] r_m;
    logic [DW-1:0] r_w;
    logic [DW-1:0] r_wa;      // A as it was before EXEC; the address of a following M write
    logic [AW-1:0] w_pc_inc;
    logic          w_take;
    logic          w_unused_ir;

    // IR[14:13] carry no meaning for this machine.
    assign w_unused_ir = ^r_ir[14:13];

    assign w_pc_inc = r_pc + AW'(1);
    assign w_take   = (r_ir[2] & bus.alu_ng) |
                      (r_ir[1] & bus.alu_zr) |
                      (r_ir[0] & ~bus.alu_ng & ~bus.alu_zr);

    assign bus.imem_addr  = r_pc;
    assign bus.dmem_addr  = (r_state == S_MEMWR) ? r_wa : r_a;
    assign bus.dmem_wdata = r_w;
    assign bus.alu_x      = r_d;
    assign bus.alu_y      = r_ir[12] ? r_m : r_a;

    assign pc_o = r_pc;
    assign a_o  = r_a;
    assign d_o  = r_d;

    always_comb begin
        w_next       = r_state;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b0;
        case (r_state)
            S_FETCH: begin
                bus.imem_req = r_run;
                if (r_run && bus.imem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (!r_ir[15])     w_next = S_FETCH;
                else if (r_ir[12]) w_next = S_MEMRD;
                else               w_next = S_EXEC;
            end
            S_MEMRD: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ack) w_next = S_EXEC;
            end
            S_EXEC: begin
                {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = r_ir[11:6];
                w_next = r_ir[3] ? S_MEMWR : S_FETCH;
            end
            S_MEMWR: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = 1'b1;
                if (bus.dmem_ack) w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_ir    <= '0;
            r_pc    <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_m     <= '0;
            r_w     <= '0;
            r_wa    <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (r_run && bus.imem_ack) r_ir <= bus.imem_data;
                end
                S_DECODE: begin
                    if (!r_ir[15]) begin
                        r_a  <= r_ir[DW-1:0];
                        r_pc <= w_pc_inc;
                    end
                end
                S_MEMRD: begin
                    if (bus.dmem_ack) r_m <= bus.dmem_rdata;
                end
                S_EXEC: begin
                    // Non-blocking updates: jump target and write address both see the old A.
                    r_wa <= r_a;
                    if (r_ir[5]) r_a <= bus.alu_o;
                    if (r_ir[4]) r_d <= bus.alu_o;
                    if (r_ir[3]) r_w <= bus.alu_o;
                    r_pc <= w_take ? AW'(r_a) : w_pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
